// File: rtl/demux_router_hs_pkg.sv
// Shared constants and helpers for the demux router; latency/backpressure n/a.
package demux_router_hs_pkg;

    localparam int DEMUX_DATA_W_DEF = 32;
    localparam int DEMUX_N_OUT_DEF  = 32;
    localparam int DEMUX_DROP_CNT_W = 8;

    function automatic logic [DEMUX_DROP_CNT_W-1:0] sat_inc(input logic [DEMUX_DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_router_hs_out_slot.sv
// One-entry output slot (valid + data register), 1-cycle load-to-valid latency.
// Free when empty or draining this cycle, so a full slot can refill with no bubble.
module demux_router_hs_out_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_dat_i,
    input  logic              drain_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] dat_o,
    output logic              free_o
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = load_dat_i;
        end else if (vld_q && drain_i) begin
            // data keeps its last value after a drain
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign free_o = !vld_q || drain_i;

endmodule

// File: rtl/demux_router_hs.sv
// Registered 1-to-N demux with broadcast and out-of-range drop; 1-cycle latency.
// in_ready follows the addressed slot (all slots for broadcast); bad selects always accepted.
module demux_router_hs
    import demux_router_hs_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF,
    parameter int N_OUT  = DEMUX_N_OUT_DEF,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_bcast,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_ready,
    output logic [N_OUT*DATA_W-1:0]     out_data,
    output logic                        err_sel,
    output logic [DEMUX_DROP_CNT_W-1:0] drop_cnt
);

    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] slot_load;
    logic             sel_free;
    logic             sel_in_range;
    logic             xfer;
    logic             drop;

    logic                        err_q, err_d;
    logic [DEMUX_DROP_CNT_W-1:0] cnt_q, cnt_d;

    // Decoding by equality keeps non-power-of-two N_OUT from indexing past the array.
    always_comb begin
        sel_hit  = '0;
        sel_free = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                sel_free   = slot_free[k];
            end
        end
    end

    assign sel_in_range = |sel_hit;

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &slot_free;
        end else if (sel_in_range) begin
            in_ready = sel_free;
        end
    end

    assign xfer      = in_valid && in_ready;
    assign slot_load = xfer ? (in_bcast ? {N_OUT{1'b1}} : sel_hit) : '0;
    assign drop      = xfer && !in_bcast && !sel_in_range;

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (drop) begin
            err_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_sel  = err_q;
    assign drop_cnt = cnt_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_router_hs_out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load_i    (slot_load[g]),
            .load_dat_i(in_data),
            .drain_i   (out_ready[g]),
            .vld_o     (out_valid[g]),
            .dat_o     (out_data[g*DATA_W +: DATA_W]),
            .free_o    (slot_free[g])
        );
    end

endmodule

// File: tb/tb_demux_router_hs.sv
// Bench for demux_router_hs: a 32-channel and a 24-channel instance share payload/select.
module tb_demux_router_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [4:0]  in_sel;
    logic        in_bcast;
    logic [1:0]  vld;
    logic [63:0] ordy [2];

    logic          rdy_a, err_a;
    logic [31:0]   ov_a;
    logic [1023:0] od_a;
    logic [7:0]    cnt_a;
    logic          rdy_b, err_b;
    logic [23:0]   ov_b;
    logic [767:0]  od_b;
    logic [7:0]    cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_router_hs #(.DATA_W(32), .N_OUT(32), .SEL_W(5)) dut_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy_a), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov_a), .out_ready(ordy[0][31:0]),
        .out_data(od_a), .err_sel(err_a), .drop_cnt(cnt_a)
    );

    demux_router_hs #(.DATA_W(32), .N_OUT(24), .SEL_W(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy_b), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(ov_b), .out_ready(ordy[1][23:0]),
        .out_data(od_b), .err_sel(err_b), .drop_cnt(cnt_b)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-channel occupancy and contents, error flag, drop count.
    logic        mv   [2][64];
    logic [31:0] md   [2][64];
    logic        merr [2];
    int          mcnt [2];

    function automatic int nch(input int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic logic mfree(input int d, input int k);
        return !mv[d][k] || ordy[d][k];
    endfunction

    function automatic logic exp_rdy(input int d);
        logic r;
        r = 1'b1;
        if (in_bcast) begin
            for (int k = 0; k < nch(d); k++) r = r && mfree(d, k);
        end else if (int'(in_sel) < nch(d)) begin
            r = mfree(d, int'(in_sel));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 64; k++) begin
                    mv[d][k] = 1'b0;
                    md[d][k] = '0;
                end
                merr[d] = 1'b0;
                mcnt[d] = 0;
            end
        end else begin
            check("a_in_ready", rdy_a, exp_rdy(0));
            check("a_err_sel", err_a, merr[0]);
            check("a_drop_cnt", cnt_a, mcnt[0]);
            for (int k = 0; k < 32; k++) begin
                check($sformatf("a_valid%0d", k), ov_a[k], mv[0][k]);
                check($sformatf("a_data%0d", k), od_a[k*32 +: 32], md[0][k]);
            end
            check("b_in_ready", rdy_b, exp_rdy(1));
            check("b_err_sel", err_b, merr[1]);
            check("b_drop_cnt", cnt_b, mcnt[1]);
            for (int k = 0; k < 24; k++) begin
                check($sformatf("b_valid%0d", k), ov_b[k], mv[1][k]);
                check($sformatf("b_data%0d", k), od_b[k*32 +: 32], md[1][k]);
            end
            // Advance to the state after the coming edge; inputs are stable until then.
            for (int d = 0; d < 2; d++) begin
                logic xf;
                xf = vld[d] && exp_rdy(d);
                for (int k = 0; k < nch(d); k++)
                    if (mv[d][k] && ordy[d][k]) mv[d][k] = 1'b0;
                if (xf) begin
                    if (in_bcast) begin
                        for (int k = 0; k < nch(d); k++) begin
                            mv[d][k] = 1'b1;
                            md[d][k] = in_data;
                        end
                    end else if (int'(in_sel) < nch(d)) begin
                        mv[d][int'(in_sel)] = 1'b1;
                        md[d][int'(in_sel)] = in_data;
                    end else begin
                        merr[d] = 1'b1;
                        if (mcnt[d] < 255) mcnt[d]++;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] oh;
        rst      = 1'b1;
        vld      = '0;
        in_data  = '0;
        in_sel   = '0;
        in_bcast = 1'b0;
        ordy[0]  = '1;
        ordy[1]  = '1;
        #6;
        check("rst_valid_a", ov_a, 0);
        check("rst_data_a0", od_a[31:0], 0);
        check("rst_err_a", err_a, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_valid_b", ov_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Ramp: one word per cycle to each channel in turn.
        for (int i = 0; i < 32; i++) begin
            in_sel  = 5'(i);
            in_data = 32'hA5A5A5A5 + 32'(i);
            vld[0]  = 1'b1;
            #1 check("ramp_rdy", rdy_a, 1);
            tick();
            oh    = '0;
            oh[i] = 1'b1;
            check("ramp_valid", ov_a, oh);
            check("ramp_data", od_a[i*32 +: 32], 32'hA5A5A5A5 + 32'(i));
        end
        vld[0] = 1'b0;
        tick();

        // Backpressure on ch5 while ch6 keeps flowing.
        ordy[0][5] = 1'b0;
        in_sel  = 5'd5;
        in_data = 32'h5000_0001;
        vld[0]  = 1'b1;
        tick();
        in_data = 32'h5000_0002;
        #1 check("bp_rdy_stall", rdy_a, 0);
        check("bp_ch5_held", od_a[5*32 +: 32], 32'h5000_0001);
        in_sel  = 5'd6;
        in_data = 32'h6000_0001;
        #1 check("bp_rdy_ch6", rdy_a, 1);
        tick();
        check("bp_ch6_valid", ov_a[6], 1);
        check("bp_ch6_data", od_a[6*32 +: 32], 32'h6000_0001);
        in_sel  = 5'd5;
        in_data = 32'h5000_0002;
        #1 check("bp_rdy_stall2", rdy_a, 0);
        tick();
        check("bp_ch5_stable", od_a[5*32 +: 32], 32'h5000_0001);
        ordy[0][5] = 1'b1;
        #1 check("bp_rdy_release", rdy_a, 1);
        tick();
        check("bp_ch5_second", od_a[5*32 +: 32], 32'h5000_0002);
        check("bp_ch5_valid", ov_a[5], 1);
        vld[0] = 1'b0;
        tick();

        // Broadcast, then a blocked broadcast with ch31 stalled.
        in_bcast = 1'b1;
        in_data  = 32'hDEADBEEF;
        vld[0]   = 1'b1;
        #1 check("bc_rdy", rdy_a, 1);
        tick();
        vld[0]      = 1'b0;
        ordy[0][31] = 1'b0;
        check("bc_all_valid", ov_a, 32'hFFFF_FFFF);
        check("bc_b_untouched", ov_b, 0);
        tick();
        in_data = 32'hCAFEF00D;
        vld[0]  = 1'b1;
        #1 check("bc_blocked_rdy", rdy_a, 0);
        tick();
        check("bc_blocked_valid", ov_a, 32'h8000_0000);
        check("bc_blocked_d0", od_a[31:0], 32'hDEADBEEF);
        check("bc_blocked_d31", od_a[31*32 +: 32], 32'hDEADBEEF);
        vld[0]      = 1'b0;
        in_bcast    = 1'b0;
        ordy[0][31] = 1'b1;
        tick();

        // Drain and refill ch2 in the same cycle.
        ordy[0][2] = 1'b0;
        in_sel  = 5'd2;
        in_data = 32'h2000_0001;
        vld[0]  = 1'b1;
        tick();
        in_data    = 32'h2000_0002;
        ordy[0][2] = 1'b1;
        #1 check("dr_rdy", rdy_a, 1);
        tick();
        check("dr_valid", ov_a[2], 1);
        check("dr_data", od_a[2*32 +: 32], 32'h2000_0002);
        vld[0] = 1'b0;
        tick();

        // Out-of-range select on the 24-channel instance.
        in_sel  = 5'd30;
        in_data = 32'h0BAD_0000;
        vld[1]  = 1'b1;
        #1 check("oor_rdy", rdy_b, 1);
        tick();
        check("oor_err", err_b, 1);
        check("oor_cnt1", cnt_b, 8'd1);
        check("oor_no_valid", ov_b, 0);
        repeat (300) tick();
        check("oor_cnt_sat", cnt_b, 8'hFF);
        check("oor_err_sticky", err_b, 1);
        vld[1] = 1'b0;
        tick();

        // Asynchronous reset with ch0..3 holding words.
        ordy[0] = '0;
        for (int i = 0; i < 4; i++) begin
            in_sel  = 5'(i);
            in_data = 32'h3000_0000 + 32'(i);
            vld[0]  = 1'b1;
            tick();
        end
        vld[0] = 1'b0;
        check("rm_filled", ov_a[3:0], 4'hF);
        #2 rst = 1'b1;
        #1;
        check("rm_valid_a", ov_a, 0);
        check("rm_data_a0", od_a[31:0], 0);
        check("rm_err_b", err_b, 0);
        check("rm_cnt_b", cnt_b, 0);
        tick();
        rst     = 1'b0;
        ordy[0] = '1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
